// File: rtl/mem_stage.sv
// Memory-access stage: aligns and extends load data, holds the returned SRAM word
// across write-back stalls, and forwards the result bundle to write-back and decode.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic [37:0] es_rf_collect,
  input  logic [4:0]  es_ld_op,
  input  logic [1:0]  es_mem_offset,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [37:0] ms_rf_collect,
  output logic        ms_res_from_mem
);

  logic        r_ms_valid;
  logic        r_first;
  logic        r_rf_we;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_alu_result;
  logic [31:0] r_pc;
  logic [4:0]  r_ld_op;
  logic [1:0]  r_offset;
  logic [31:0] r_rdata_buf;

  logic        w_ready_go;
  logic        w_accept;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_final_wdata;

  assign w_ready_go     = 1'b1;
  assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
  assign ms_to_ws_valid = r_ms_valid & w_ready_go;
  assign w_accept       = es_to_ms_valid & ms_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_valid   <= 1'b0;
      r_first      <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= 5'd0;
      r_alu_result <= 32'd0;
      r_pc         <= 32'd0;
      r_ld_op      <= 5'd0;
      r_offset     <= 2'd0;
      r_rdata_buf  <= 32'd0;
    end else begin
      if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end
      if (w_accept) begin
        r_pc         <= es_pc;
        r_rf_we      <= es_rf_collect[37];
        r_rf_waddr   <= es_rf_collect[36:32];
        r_alu_result <= es_rf_collect[31:0];
        r_ld_op      <= es_ld_op;
        r_offset     <= es_mem_offset;
        r_first      <= 1'b1;
      end else begin
        r_first      <= 1'b0;
      end
      // SRAM output is only meaningful in the first cycle; keep a copy for stalls
      if (r_first) begin
        r_rdata_buf <= data_sram_rdata;
      end
    end
  end

  assign w_word = r_first ? data_sram_rdata : r_rdata_buf;
  assign w_half = r_offset[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (r_offset)
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  // ld_op is one-hot {ld_hu, ld_bu, ld_w, ld_h, ld_b}; all-zero passes the ALU result
  always_comb begin
    w_final_wdata = r_alu_result;
    if (r_ld_op[0]) begin
      w_final_wdata = {{24{w_byte[7]}}, w_byte};
    end else if (r_ld_op[1]) begin
      w_final_wdata = {{16{w_half[15]}}, w_half};
    end else if (r_ld_op[2]) begin
      w_final_wdata = w_word;
    end else if (r_ld_op[3]) begin
      w_final_wdata = {24'd0, w_byte};
    end else if (r_ld_op[4]) begin
      w_final_wdata = {16'd0, w_half};
    end
  end

  assign ms_pc           = r_pc;
  assign ms_rf_collect   = {r_rf_we & r_ms_valid, r_rf_waddr, w_final_wdata};
  assign ms_res_from_mem = r_ms_valid & (|r_ld_op);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard-driven bench for mem_stage: expected write-back bundles are queued
// when an instruction is issued and compared when it is offered to write-back.
module tb_mem_stage;

  localparam logic [4:0] LD_NONE = 5'b00000;
  localparam logic [4:0] LD_B    = 5'b00001;
  localparam logic [4:0] LD_H    = 5'b00010;
  localparam logic [4:0] LD_W    = 5'b00100;
  localparam logic [4:0] LD_BU   = 5'b01000;
  localparam logic [4:0] LD_HU   = 5'b10000;

  logic        clk;
  logic        resetn;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [37:0] es_rf_collect;
  logic [4:0]  es_ld_op;
  logic [1:0]  es_mem_offset;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [37:0] ms_rf_collect;
  logic        ms_res_from_mem;

  typedef struct {
    logic [31:0] pc;
    logic [37:0] rf;
    logic        res;
  } expT;

  expT sb[$];
  int nCompared;
  int nMismatched;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .es_pc           (es_pc),
    .es_rf_collect   (es_rf_collect),
    .es_ld_op        (es_ld_op),
    .es_mem_offset   (es_mem_offset),
    .data_sram_rdata (data_sram_rdata),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_pc           (ms_pc),
    .ms_rf_collect   (ms_rf_collect),
    .ms_res_from_mem (ms_res_from_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extraction written from the byte-lane view of the loaded word
  function automatic logic [31:0] modelWdata(input logic [4:0] ldOp, input logic [1:0] off,
                                             input logic [31:0] word, input logic [31:0] alu);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = word >> (off * 8);
    res = alu;
    if (ldOp == LD_B)       res = shifted[7] ? (shifted | 32'hFFFF_FF00) : (shifted & 32'h0000_00FF);
    else if (ldOp == LD_BU) res = shifted & 32'h0000_00FF;
    else if (ldOp == LD_H || ldOp == LD_HU) begin
      shifted = off[1] ? (word >> 16) : word;
      if (ldOp == LD_H && shifted[15]) res = shifted | 32'hFFFF_0000;
      else                             res = shifted & 32'h0000_FFFF;
    end
    else if (ldOp == LD_W)  res = word;
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction on the execute side and queue what write-back should see
  task automatic issue(input logic [31:0] pc, input logic [4:0] waddr, input logic [31:0] alu,
                       input logic [4:0] ldOp, input logic [1:0] off, input logic [31:0] wdata);
    expT e;
    es_to_ms_valid = 1'b1;
    es_pc          = pc;
    es_rf_collect  = {1'b1, waddr, alu};
    es_ld_op       = ldOp;
    es_mem_offset  = off;
    e.pc  = pc;
    e.rf  = {1'b1, waddr, wdata};
    e.res = (ldOp != LD_NONE);
    sb.push_back(e);
  endtask

  task automatic idleInputs();
    es_to_ms_valid = 1'b0;
    es_pc          = 32'hBAD0_0000;
    es_rf_collect  = {1'b1, 5'd31, 32'hBAD0_BAD0};
    es_ld_op       = LD_W;
    es_mem_offset  = 2'd1;
  endtask

  task automatic test_reset();
    resetn          = 1'b0;
    ws_allowin      = 1'b1;
    data_sram_rdata = 32'h0;
    idleInputs();
    #3;
    nCompared++;
    if (ms_to_ws_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", ms_to_ws_valid); end
    nCompared++;
    if (ms_allowin !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_allowin: got %b expected 1", ms_allowin); end
    nCompared++;
    if (ms_pc !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_pc: got %h expected 0", ms_pc); end
    nCompared++;
    if (ms_rf_collect !== 38'h0) begin nMismatched++; $display("[TB] FAIL reset_rf: got %h expected 0", ms_rf_collect); end
    nCompared++;
    if (ms_res_from_mem !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_res: got %b expected 0", ms_res_from_mem); end
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // Runs a table of single loads, each followed by the SRAM word one cycle later
  task automatic test_extract();
    logic [4:0]  ops   [5] = '{LD_B, LD_BU, LD_HU, LD_H, LD_H};
    logic [1:0]  offs  [5] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0};
    logic [31:0] wants [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80AB, 32'hFFFF_80AB, 32'hFFFF_CD12};
    expT e;
    for (int i = 0; i < 5; i++) begin
      issue(32'h100 + 32'(i * 4), 5'd5, 32'h0BAD_0000, ops[i], offs[i], wants[i]);
      tick();
      idleInputs();
      data_sram_rdata = 32'h80AB_CD12;
      @(negedge clk);
      e = sb.pop_front();
      nCompared++;
      if (ms_to_ws_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL extract%0d_valid: got %b expected 1", i, ms_to_ws_valid); end
      nCompared++;
      if (ms_rf_collect !== e.rf) begin nMismatched++; $display("[TB] FAIL extract%0d_rf: got %h expected %h", i, ms_rf_collect, e.rf); end
      nCompared++;
      if (ms_res_from_mem !== e.res || ms_pc !== e.pc) begin
        nMismatched++; $display("[TB] FAIL extract%0d_pc_res: got %h/%b expected %h/%b", i, ms_pc, ms_res_from_mem, e.pc, e.res);
      end
      tick();
    end
  endtask

  task automatic test_stall_hold();
    expT e;
    ws_allowin = 1'b0;
    issue(32'h200, 5'd7, 32'h0, LD_W, 2'd0, 32'h1234_5678);
    tick();
    idleInputs();
    data_sram_rdata = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nCompared++;
      if (ms_allowin !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall%0d_allowin: got %b expected 0", c, ms_allowin); end
      nCompared++;
      if (ms_rf_collect[31:0] !== 32'h1234_5678) begin
        nMismatched++; $display("[TB] FAIL stall%0d_wdata: got %h expected 12345678", c, ms_rf_collect[31:0]);
      end
      tick();
      data_sram_rdata = 32'hDEAD_BEEF;
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    nCompared++;
    if (ms_to_ws_valid !== 1'b1 || ms_rf_collect !== e.rf) begin
      nMismatched++; $display("[TB] FAIL stall_release: got %b/%h expected 1/%h", ms_to_ws_valid, ms_rf_collect, e.rf);
    end
    tick();
    @(negedge clk);
    nCompared++;
    if (ms_to_ws_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_drained: got %b expected 0", ms_to_ws_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    expT e;
    issue(32'h300, 5'd9, 32'h11, LD_NONE, 2'd0, 32'h11);
    tick();
    issue(32'h304, 5'd10, 32'h0, LD_W, 2'd0, 32'h22);
    data_sram_rdata = 32'h9999_9999;
    @(negedge clk);
    e = sb.pop_front();
    nCompared++;
    if (ms_rf_collect !== e.rf || ms_pc !== e.pc) begin
      nMismatched++; $display("[TB] FAIL b2b_first: got %h/%h expected %h/%h", ms_pc, ms_rf_collect, e.pc, e.rf);
    end
    nCompared++;
    if (ms_res_from_mem !== 1'b0 || ms_allowin !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL b2b_first_res_allowin: got %b/%b expected 0/1", ms_res_from_mem, ms_allowin);
    end
    tick();
    idleInputs();
    data_sram_rdata = 32'h22;
    @(negedge clk);
    e = sb.pop_front();
    nCompared++;
    if (ms_to_ws_valid !== 1'b1 || ms_rf_collect !== e.rf || ms_pc !== e.pc) begin
      nMismatched++; $display("[TB] FAIL b2b_second: got %b/%h/%h expected 1/%h/%h", ms_to_ws_valid, ms_pc, ms_rf_collect, e.pc, e.rf);
    end
    nCompared++;
    if (ms_res_from_mem !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_second_res: got %b expected 1", ms_res_from_mem); end
    tick();
  endtask

  task automatic test_bubble();
    expT e;
    issue(32'h400, 5'd3, 32'hAAAA_0001, LD_NONE, 2'd0, 32'hAAAA_0001);
    tick();
    idleInputs();
    @(negedge clk);
    e = sb.pop_front();
    nCompared++;
    if (ms_rf_collect !== e.rf) begin nMismatched++; $display("[TB] FAIL bubble_before: got %h expected %h", ms_rf_collect, e.rf); end
    tick();
    issue(32'h408, 5'd4, 32'h0, LD_BU, 2'd1, 32'h0000_00CD);
    @(negedge clk);
    nCompared++;
    if (ms_to_ws_valid !== 1'b0 || ms_rf_collect[37] !== 1'b0 || ms_res_from_mem !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL bubble_gap: got %b/%b/%b expected 0/0/0", ms_to_ws_valid, ms_rf_collect[37], ms_res_from_mem);
    end
    tick();
    idleInputs();
    data_sram_rdata = 32'h80AB_CD12;
    @(negedge clk);
    e = sb.pop_front();
    nCompared++;
    if (ms_rf_collect !== e.rf) begin nMismatched++; $display("[TB] FAIL bubble_after: got %h expected %h", ms_rf_collect, e.rf); end
    tick();
  endtask

  task automatic test_random_loads();
    logic [4:0]  opSet [6] = '{LD_NONE, LD_B, LD_H, LD_W, LD_BU, LD_HU};
    logic [4:0]  op;
    logic [1:0]  off;
    logic [31:0] word;
    logic [31:0] alu;
    expT e;
    for (int i = 0; i < 8; i++) begin
      op   = opSet[$urandom_range(0, 5)];
      off  = 2'($urandom_range(0, 3));
      word = $urandom;
      alu  = $urandom;
      issue(32'h500 + 32'(i * 4), 5'(i + 12), alu, op, off, modelWdata(op, off, word, alu));
      tick();
      idleInputs();
      data_sram_rdata = word;
      @(negedge clk);
      e = sb.pop_front();
      nCompared++;
      if (ms_rf_collect !== e.rf || ms_res_from_mem !== e.res) begin
        nMismatched++;
        $display("[TB] FAIL random%0d: op %b off %0d word %h got %h/%b expected %h/%b",
                 i, op, off, word, ms_rf_collect, ms_res_from_mem, e.rf, e.res);
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    issue(32'h600, 5'd8, 32'h5555_5555, LD_NONE, 2'd0, 32'h5555_5555);
    void'(sb.pop_back());
    ws_allowin = 1'b0;
    tick();
    idleInputs();
    @(negedge clk);
    nCompared++;
    if (ms_to_ws_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL midreset_before: got %b expected 1", ms_to_ws_valid); end
    #2;
    resetn = 1'b0;
    #1;
    nCompared++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL midreset_handshake: got %b/%b expected 0/1", ms_to_ws_valid, ms_allowin);
    end
    nCompared++;
    if (ms_rf_collect !== 38'h0 || ms_res_from_mem !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL midreset_rf: got %h/%b expected 0/0", ms_rf_collect, ms_res_from_mem);
    end
    tick();
    resetn     = 1'b1;
    ws_allowin = 1'b1;
    tick();
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_extract();
    test_stall_hold();
    test_back_to_back();
    test_bubble();
    test_random_loads();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
